rca_seq_ctrl: RTL and testbench

//  Sequencer for the multi-cycle wide adder/subtractor.
//  - Adds or subtracts two OP_BITS-wide operands by reusing one CHUNK_BITS-wide rca_nbits instance.
//  - Processes one chunk per cycle, LSB chunk first, and registers the carry between chunks.
//  - Connects to the CPA datapath through a valid/ready handshake on both the operand side and the result side.

---
 rtl/rca_pkg.sv | 11 +
 rtl/rca_nbits.sv | 24 ++
 rtl/rca_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_rca_seq_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared types for the multi-cycle wide adder/subtractor sequencer.
// Holds the sequencer FSM state encoding. There are no ports.
package rca_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } rca_state_e;

endpackage : rca_pkg

// File: rtl/rca_nbits.sv
// Combinational BITS-wide ripple-carry adder chunk.
// Ports:
//   a  - addend A
//   b  - addend B
//   ci - carry-in
//   s  - sum bits
//   co - carry-out of the MSB
module rca_nbits #(
   parameter int unsigned BITS = 32
) (
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   input  logic            ci,
   output logic [BITS-1:0] s,
   output logic            co
);

   logic [BITS:0] sum_ext;

   assign sum_ext = {1'b0, a} + {1'b0, b} + {{BITS{1'b0}}, ci};
   assign s       = sum_ext[BITS-1:0];
   assign co      = sum_ext[BITS];

endmodule : rca_nbits

// File: rtl/rca_seq_ctrl.sv
// Sequencer for a multi-cycle wide adder/subtractor. One CHUNK_BITS-wide rca_nbits
// instance is reused for NCHUNK cycles, LSB chunk first, with the carry registered
// between chunks. Subtraction is a + ~b + 1 - ci, so the captured carry is ci ^ sub.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - synchronous reset, active-low
//   in_valid  - operand request
//   in_ready  - high only while idle
//   a, b      - OP_BITS-wide operands
//   ci        - carry-in (add) / borrow-in (sub)
//   sub       - 1: s = a - b - ci, 0: s = a + b + ci
//   out_valid - result held and available
//   out_ready - result consumer ready
//   s         - registered result
//   co        - carry-out of bit OP_BITS-1 (for sub, 1 means no borrow)
module rca_seq_ctrl
   import rca_pkg::*;
#(
   parameter int unsigned OP_BITS    = 128,
   parameter int unsigned CHUNK_BITS = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [OP_BITS-1:0] a,
   input  logic [OP_BITS-1:0] b,
   input  logic               ci,
   input  logic               sub,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OP_BITS-1:0] s,
   output logic               co
);

   localparam int unsigned NCHUNK = OP_BITS / CHUNK_BITS;
   localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

   if ((OP_BITS % CHUNK_BITS) != 0) begin : g_bad_params
      $error("OP_BITS must be a multiple of CHUNK_BITS");
   end

   rca_state_e         state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [OP_BITS-1:0] a_sh_q, a_sh_d;
   logic [OP_BITS-1:0] b_sh_q, b_sh_d;
   logic [OP_BITS-1:0] s_q, s_d;
   logic               carry_q, carry_d;
   logic               co_q, co_d;

   logic [CHUNK_BITS-1:0] chunk_sum;
   logic                  chunk_co;
   logic [OP_BITS-1:0]    s_shift;

   rca_nbits #(
      .BITS(CHUNK_BITS)
   ) u_rca (
      .a  (a_sh_q[CHUNK_BITS-1:0]),
      .b  (b_sh_q[CHUNK_BITS-1:0]),
      .ci (carry_q),
      .s  (chunk_sum),
      .co (chunk_co)
   );

   // New chunks enter from the MSB side so the LSB chunk ends up at the bottom.
   if (NCHUNK == 1) begin : g_single
      assign s_shift = chunk_sum;
   end else begin : g_multi
      assign s_shift = {chunk_sum, s_q[OP_BITS-1:CHUNK_BITS]};
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      s_d     = s_q;
      carry_d = carry_q;
      co_d    = co_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = sub ? ~b : b;
               carry_d = ci ^ sub;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            s_d     = s_shift;
            a_sh_d  = a_sh_q >> CHUNK_BITS;
            b_sh_d  = b_sh_q >> CHUNK_BITS;
            carry_d = chunk_co;
            if (idx_q == IDX_LAST) begin
               co_d    = chunk_co;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         co_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         co_q    <= co_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign s         = s_q;
   assign co        = co_q;

endmodule : rca_seq_ctrl

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl (128-bit operands, 32-bit chunks).
module tb_rca_seq_ctrl;

   localparam int unsigned W      = 128;
   localparam int          NCHUNK = 4;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ci;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         co;

   int checks;
   int failures;

   rca_seq_ctrl #(
      .OP_BITS    (W),
      .CHUNK_BITS (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .co        (co)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [W:0] obs, input logic [W:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain modular arithmetic; for sub, co is "no borrow occurred".
   function automatic logic [W:0] ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                         input logic rci, input logic rsub);
      logic [W+1:0] t;
      logic [W-1:0] d;
      logic         nb;
      if (!rsub) begin
         t = {2'b00, ra} + {2'b00, rb} + {{(W+1){1'b0}}, rci};
         return t[W:0];
      end
      d  = ra - rb - {{(W-1){1'b0}}, rci};
      nb = ({1'b0, ra} >= ({1'b0, rb} + {{W{1'b0}}, rci}));
      return {nb, d};
   endfunction

   function automatic logic [W-1:0] rand_w();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: accept, count latency, check result, optional DONE stall.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci,
                         input logic tsub, input int stall, input string tag);
      logic [W:0] exp;
      int         lat;
      exp = ref_op(ta, tb, tci, tsub);
      check_eq({tag, "_in_ready"}, {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
      a        = ta;
      b        = tb;
      ci       = tci;
      sub      = tsub;
      in_valid = 1'b1;
      step();
      // Scramble inputs mid-RUN; they must be ignored.
      in_valid = 1'b0;
      a        = rand_w();
      b        = rand_w();
      ci       = 1'($urandom);
      sub      = 1'($urandom);
      check_eq({tag, "_run_busy"}, {{(W-1){1'b0}}, in_ready, out_valid}, '0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
         if (lat == 1) in_valid = 1'b1;
      end
      in_valid = 1'b0;
      check_eq({tag, "_latency"}, (W+1)'(lat), (W+1)'(NCHUNK));
      check_eq({tag, "_result"}, {co, s}, exp);
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'($urandom);
         a        = rand_w();
         b        = rand_w();
         step();
         check_eq({tag, "_stall_hs"}, {{(W-1){1'b0}}, out_valid, in_ready},
                  {{(W-1){1'b0}}, 2'b10});
         check_eq({tag, "_stall_res"}, {co, s}, exp);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_eq({tag, "_back_idle"}, {{(W-1){1'b0}}, out_valid, in_ready},
               {{(W-1){1'b0}}, 2'b01});
      check_eq({tag, "_idle_hold"}, {co, s}, exp);
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      bit           pulsed;
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      ci        = 1'b0;
      sub       = 1'b0;

      step();
      step();
      rst_n = 1'b1;
      check_eq("reset_hs", {{(W-1){1'b0}}, in_ready, out_valid}, {{(W-1){1'b0}}, 2'b10});
      check_eq("reset_res", {co, s}, '0);

      run_op('1, 128'd1, 1'b0, 1'b0, 0, "wrap_add");
      run_op(128'hFFFF_FFFF, 128'd1, 1'b0, 1'b0, 0, "chunk_carry");
      run_op(128'd5, 128'd7, 1'b0, 1'b1, 0, "sub_neg");
      run_op(128'd7, 128'd7, 1'b1, 1'b1, 0, "sub_borrow_in");
      run_op(128'd9, 128'd4, 1'b0, 1'b1, 0, "sub_pos");
      run_op(rand_w(), rand_w(), 1'b1, 1'b0, 5, "stall");

      // Abort mid-RUN: reset lands on the edge ending the 3rd RUN cycle.
      a        = rand_w();
      b        = rand_w();
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      step();
      rst_n  = 1'b1;
      pulsed = 1'b0;
      check_eq("abort_hs", {{(W-1){1'b0}}, in_ready, out_valid}, {{(W-1){1'b0}}, 2'b10});
      check_eq("abort_res", {co, s}, '0);
      for (int i = 0; i < 6; i++) begin
         step();
         if (out_valid) pulsed = 1'b1;
      end
      check_eq("abort_no_valid", {{W{1'b0}}, pulsed}, '0);
      run_op(128'd1, 128'd2, 1'b0, 1'b0, 0, "after_abort");

      for (int n = 0; n < 40; n++) begin
         ra = rand_w();
         rb = rand_w();
         case ($urandom_range(0, 4))
            0: ra = '1;
            1: rb = ra;
            2: rb = '0;
            default: ;
         endcase
         run_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_rca_seq_ctrl
